decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Registered RV32I instruction-decode pipeline stage with a valid/ready handshake and a 2-entry output buffer. It accepts a fetched instruction word plus PC and splits out opcode, funct3, funct7, rd, rs1 and rs2. It also produces the sign-extended immediate for every base format, a format class, register-use flags and an illegal-instruction flag. It sits between fetch and register-read/execute, replacing the purely combinational field split with a back-pressurable, flushable stage.

Parameters:
XLEN, 32, datapath width for pc and imm (32 or 64); imm sign-extends to XLEN.
BUF_DEPTH, 2, output buffer entries (power of two, >=2).
CHECK_FUNCT7, 1, when 1 OP/OP-IMM shift encodings with a bad funct7 flag illegal.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all buffered entries
in_valid  in  1  inst/pc valid
in_ready  out  1  stage can accept
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_pc  out  XLEN  pc of head
out_opcode  out  7  inst[6:0]
out_funct3  out  3  inst[14:12]
out_funct7  out  7  inst[31:25]
out_rd  out  5  inst[11:7]
out_rs1  out  5  inst[19:15]
out_rs2  out  5  inst[24:20]
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format class: R,I,S,B,U,J,NONE
out_uses_rs1  out  1  rs1 read required
out_uses_rs2  out  1  rs2 read required
out_writes_rd  out  1  rd written and rd!=0
out_illegal  out  1  undecodable instruction

Behaviour:
- Reset (rst_n low, async): count=0, pointers=0, out_valid=0, in_ready=1; all out_* data fields 0, out_fmt=NONE.
- Input transfer on in_valid&&in_ready. Output transfer on out_valid&&out_ready.
- in_ready = (count < BUF_DEPTH), driven from registered state only, with no combinational path from out_ready.
- Decode is combinational on in_inst and written into the buffer on transfer. Latency is 1 cycle: an accepted word is visible at the head the next cycle if the buffer was empty.
- FIFO order. Simultaneous push and pop keeps count unchanged. Pop when empty is impossible because out_valid=0.
- flush: count=0 next cycle. An input presented in the flush cycle is dropped, and in_ready=1 the next cycle. flush has priority over push and pop.
- Immediates (bit 31 sign-extended to XLEN):
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - R/NONE: imm=0.
- Format by opcode:
  - 0110011 gives R.
  - 0010011, 0000011, 1100111, 1110011 and 0001111 give I.
  - 0100011 gives S.
  - 1100011 gives B.
  - 0110111 and 0010111 give U.
  - 1101111 gives J.
  - Any other opcode gives NONE with illegal=1.
- Flags:
  - uses_rs1 for R, I (except SYSTEM with funct3=000, and MISC-MEM), S and B.
  - uses_rs2 for R, S and B.
  - writes_rd for R, I (except MISC-MEM and SYSTEM funct3=000), U and J, gated by rd!=0.
- Illegal when any of these holds:
  - inst[1:0] != 2'b11.
  - Unknown opcode.
  - CHECK_FUNCT7 and R-type funct7 is not 0000000 or 0100000.
  - funct7=0100000 with funct3 other than 000 or 101 in an R-type instruction.
  - CHECK_FUNCT7 and an OP-IMM shift has a bad funct7.
- Illegal entries still flow through with illegal=1 and writes_rd=0.
- Reset mid-operation: all entries discarded immediately, with no partial output.

Decomposition:
- The shared package carries the opcode constants, the fmt_e enum (R,I,S,B,U,J,NONE) and the decoded_t struct (fields, imm, fmt, flags).
- One sub-module, imm_gen, which is combinational: inst -> imm and fmt.
- The buffer is inline circular storage of decoded_t plus pc.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, fmt=I, imm=0xFFFFFFFF, writes_rd=1, uses_rs2=0, illegal=0.
- BEQ x0,x0,-4 (0xFE000EE3) -> fmt=B, imm=0xFFFFFFFC, uses_rs1=uses_rs2=1, writes_rd=0.
- out_ready=0, push 0x00500113 then 0x123452B7 -> in_ready=0 after the 2nd accept. Raise out_ready -> both emerge in order (imm 5, then imm 0x12345000), with no loss or duplication.
- 0x00000000 and 0x4000F033 (bad funct3 with funct7=0100000) -> illegal=1, writes_rd=0.
- Buffer full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input is absent.
- Drop rst_n asynchronously mid-stream with 2 entries held -> out_valid=0 and out_imm=0 without waiting for a clock edge. Traffic resumes cleanly after release.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: opcode constants, format class and the decoded entry layout.
package decode_stage_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // Every base immediate fits in 32 bits once sign-extended; widened to XLEN at the output.
  localparam int IMM_W = 32;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [IMM_W-1:0] imm;
    fmt_e             fmt;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
    logic             illegal;
  } decoded_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction and format classification from the opcode.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0]      inst,
  output logic [IMM_W-1:0] imm,
  output logic [2:0]       fmt
);

  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    case (inst[6:0])
      OP_OP: fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: begin
        fmt = FMT_I;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = {inst[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes on input transfer into a small circular buffer,
// head entry presented with valid/ready; flush and async reset drop all held entries.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BUF_DEPTH    = 2,
  parameter int CHECK_FUNCT7 = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd,
  output logic            out_illegal
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  // On RV64 funct7[0] is shamt[5], so it must not be judged as part of funct7.
  localparam logic [6:0] SHAMT_MASK = (XLEN == 64) ? 7'b1111110 : 7'b1111111;

  decoded_t         dec;
  decoded_t         head;
  logic [IMM_W-1:0] gen_imm;
  logic [2:0]       gen_fmt;
  logic             no_src;
  logic             illegal;
  logic [6:0]       shift_f7;

  decoded_t         ent_mem [BUF_DEPTH];
  logic [XLEN-1:0]  pc_mem  [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  decode_stage_imm_gen u_imm_gen (
    .inst (in_inst),
    .imm  (gen_imm),
    .fmt  (gen_fmt)
  );

  always_comb begin
    dec        = '0;
    dec.opcode = in_inst[6:0];
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    dec.rd     = in_inst[11:7];
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.imm    = gen_imm;
    dec.fmt    = fmt_e'(gen_fmt);

    no_src   = (dec.opcode == OP_MISC_MEM) || (dec.opcode == OP_SYSTEM && dec.funct3 == 3'b000);
    shift_f7 = dec.funct7 & SHAMT_MASK;
    illegal  = (in_inst[1:0] != 2'b11) || (dec.fmt == FMT_NONE);

    if (dec.opcode == OP_OP) begin
      if (CHECK_FUNCT7 != 0 && dec.funct7 != 7'b0000000 && dec.funct7 != 7'b0100000)
        illegal = 1'b1;
      if (dec.funct7 == 7'b0100000 && dec.funct3 != 3'b000 && dec.funct3 != 3'b101)
        illegal = 1'b1;
    end
    if (dec.opcode == OP_IMM && CHECK_FUNCT7 != 0) begin
      if (dec.funct3 == 3'b001 && shift_f7 != 7'b0000000)
        illegal = 1'b1;
      if (dec.funct3 == 3'b101 && shift_f7 != 7'b0000000 && shift_f7 != 7'b0100000)
        illegal = 1'b1;
    end

    dec.uses_rs1  = (dec.fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) && !no_src;
    dec.uses_rs2  = dec.fmt inside {FMT_R, FMT_S, FMT_B};
    dec.writes_rd = (dec.fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && !no_src
                    && (dec.rd != 5'd0) && !illegal;
    dec.illegal   = illegal;
  end

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_mem[wr_ptr] <= dec;
      pc_mem[wr_ptr]  <= in_pc;
    end
  end

  always_comb begin
    head          = ent_mem[rd_ptr];
    out_pc        = '0;
    out_opcode    = '0;
    out_funct3    = '0;
    out_funct7    = '0;
    out_rd        = '0;
    out_rs1       = '0;
    out_rs2       = '0;
    out_imm       = '0;
    out_fmt       = FMT_NONE;
    out_uses_rs1  = 1'b0;
    out_uses_rs2  = 1'b0;
    out_writes_rd = 1'b0;
    out_illegal   = 1'b0;
    if (out_valid) begin
      out_pc        = pc_mem[rd_ptr];
      out_opcode    = head.opcode;
      out_funct3    = head.funct3;
      out_funct7    = head.funct7;
      out_rd        = head.rd;
      out_rs1       = head.rs1;
      out_rs2       = head.rs2;
      out_imm       = XLEN'($signed(head.imm));
      out_fmt       = head.fmt;
      out_uses_rs1  = head.uses_rs1;
      out_uses_rs2  = head.uses_rs2;
      out_writes_rd = head.writes_rd;
      out_illegal   = head.illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference decoder predicts each accepted word,
// the monitor compares every output transfer against the queue head.
module tb_decode_stage;

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_NONE = 3'd6;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_uses_rs1;
  logic        out_uses_rs2;
  logic        out_writes_rd;
  logic        out_illegal;

  decode_stage #(.XLEN(32), .BUF_DEPTH(2), .CHECK_FUNCT7(1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_opcode    (out_opcode),
    .out_funct3    (out_funct3),
    .out_funct7    (out_funct7),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_imm       (out_imm),
    .out_fmt       (out_fmt),
    .out_uses_rs1  (out_uses_rs1),
    .out_uses_rs2  (out_uses_rs2),
    .out_writes_rd (out_writes_rd),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    e.pc = pc;  e.op = i[6:0];  e.f3 = i[14:12];  e.f7 = i[31:25];
    e.rd = i[11:7];  e.rs1 = i[19:15];  e.rs2 = i[24:20];
    e.imm = 32'h0;  e.fmt = F_NONE;
    e.u1 = 1'b0;  e.u2 = 1'b0;  e.wr = 1'b0;  e.ill = 1'b0;
    case (i[6:0])
      7'h33: begin
        e.fmt = F_R;  e.u1 = 1'b1;  e.u2 = 1'b1;  e.wr = 1'b1;
        if (e.f7 != 7'h00 && e.f7 != 7'h20) e.ill = 1'b1;
        if (e.f7 == 7'h20 && e.f3 != 3'd0 && e.f3 != 3'd5) e.ill = 1'b1;
      end
      7'h13: begin
        e.fmt = F_I;  e.imm = {{20{i[31]}}, i[31:20]};  e.u1 = 1'b1;  e.wr = 1'b1;
        if (e.f3 == 3'd1 && e.f7 != 7'h00) e.ill = 1'b1;
        if (e.f3 == 3'd5 && e.f7 != 7'h00 && e.f7 != 7'h20) e.ill = 1'b1;
      end
      7'h03, 7'h67: begin
        e.fmt = F_I;  e.imm = {{20{i[31]}}, i[31:20]};  e.u1 = 1'b1;  e.wr = 1'b1;
      end
      7'h73: begin
        e.fmt = F_I;  e.imm = {{20{i[31]}}, i[31:20]};
        e.u1 = (e.f3 != 3'd0);  e.wr = (e.f3 != 3'd0);
      end
      7'h0F: begin
        e.fmt = F_I;  e.imm = {{20{i[31]}}, i[31:20]};
      end
      7'h23: begin
        e.fmt = F_S;  e.imm = {{20{i[31]}}, i[31:25], i[11:7]};  e.u1 = 1'b1;  e.u2 = 1'b1;
      end
      7'h63: begin
        e.fmt = F_B;  e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.u1 = 1'b1;  e.u2 = 1'b1;
      end
      7'h37, 7'h17: begin
        e.fmt = F_U;  e.imm = {i[31:12], 12'h000};  e.wr = 1'b1;
      end
      7'h6F: begin
        e.fmt = F_J;  e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};  e.wr = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (i[1:0] != 2'b11) e.ill = 1'b1;
    if (e.ill || e.rd == 5'd0) e.wr = 1'b0;
    return e;
  endfunction

  // Transfers are decided at the next rising edge; inputs are stable from posedge+2.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_out", {32'h0, out_pc}, 64'hFFFF_FFFF);
          end else begin
            mon_e = sb.pop_front();
            check_eq("pc",        out_pc,        mon_e.pc);
            check_eq("opcode",    out_opcode,    mon_e.op);
            check_eq("funct3",    out_funct3,    mon_e.f3);
            check_eq("funct7",    out_funct7,    mon_e.f7);
            check_eq("rd",        out_rd,        mon_e.rd);
            check_eq("rs1",       out_rs1,       mon_e.rs1);
            check_eq("rs2",       out_rs2,       mon_e.rs2);
            check_eq("imm",       out_imm,       mon_e.imm);
            check_eq("fmt",       out_fmt,       mon_e.fmt);
            check_eq("uses_rs1",  out_uses_rs1,  mon_e.u1);
            check_eq("uses_rs2",  out_uses_rs2,  mon_e.u2);
            check_eq("writes_rd", out_writes_rd, mon_e.wr);
            check_eq("illegal",   out_illegal,   mon_e.ill);
          end
        end
        if (in_valid && in_ready) sb.push_back(model(in_inst, in_pc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) step();
    check_eq({tag, "_sb_empty"}, sb.size(), 0);
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
  endtask

  logic [31:0] tbl [12] = '{
    32'h00000000, 32'h4000F033, 32'h40005033, 32'h02000033,
    32'h40001013, 32'h40505013, 32'h00000073, 32'h0000000F,
    32'hFE112E23, 32'h008000EF, 32'h00000017, 32'hFFC18267
  };

  initial begin
    int idx;
    int cyc;
    logic acc;
    rst_n = 1'b0;  flush = 1'b0;  in_valid = 1'b0;
    in_inst = 32'h0;  in_pc = 32'h0;  out_ready = 1'b0;

    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready",  in_ready,  1'b1);
    check_eq("rst_out_fmt",   out_fmt,   F_NONE);
    check_eq("rst_out_imm",   out_imm,   32'h0);
    check_eq("rst_out_rd",    out_rd,    5'd0);
    @(posedge clk);  #2;  rst_n = 1'b1;
    step();

    // ADDI x1,x0,-1 then BEQ x0,x0,-4, consumer always ready
    out_ready = 1'b1;
    push_one(32'hFFF00093, 32'h0000_0100);
    check_eq("lat1_out_valid", out_valid, 1'b1);
    check_eq("lat1_out_imm",   out_imm,   32'hFFFF_FFFF);
    push_one(32'hFE000EE3, 32'h0000_0104);
    check_eq("beq_fmt", out_fmt, F_B);
    drain("basic");

    // Fill with consumer stalled, then release
    out_ready = 1'b0;
    push_one(32'h00500113, 32'h0000_0200);
    check_eq("one_in_ready", in_ready, 1'b1);
    push_one(32'h123452B7, 32'h0000_0204);
    check_eq("full_in_ready", in_ready, 1'b0);
    step();
    check_eq("hold_in_ready", in_ready, 1'b0);
    check_eq("hold_imm", out_imm, 32'h5);
    drain("order");

    // Illegal and mixed encodings under random backpressure
    idx = 0;
    cyc = 0;
    while (idx < 12 && cyc < 300) begin
      in_valid  = 1'b1;
      in_inst   = tbl[idx];
      in_pc     = 32'h0000_0300 + 32'(idx * 4);
      out_ready = 1'($urandom_range(0, 1));
      acc       = in_ready;
      step();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("feed_done", idx, 12);
    drain("mix");

    // Flush a full buffer while an input is offered
    out_ready = 1'b0;
    push_one(32'h00100093, 32'h0000_0800);
    push_one(32'h00200093, 32'h0000_0804);
    check_eq("pre_flush_in_ready", in_ready, 1'b0);
    flush = 1'b1;  in_valid = 1'b1;  in_inst = 32'h00700193;  in_pc = 32'h0000_0900;
    step();
    flush = 1'b0;  in_valid = 1'b0;
    check_eq("flush_out_valid", out_valid, 1'b0);
    check_eq("flush_in_ready",  in_ready,  1'b1);
    out_ready = 1'b1;
    push_one(32'h00100093, 32'h0000_0A00);
    drain("flush");

    // Async reset mid-stream with two entries held
    out_ready = 1'b0;
    push_one(32'hABC00313, 32'h0000_0B00);
    push_one(32'h123452B7, 32'h0000_0B04);
    #1;  rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_out_imm",   out_imm,   32'h0);
    check_eq("arst_in_ready",  in_ready,  1'b1);
    sb.delete();
    @(posedge clk);  #2;  rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    push_one(32'h00300213, 32'h0000_0C00);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
